tiny_alu_cmd_sequencer: RTL and testbench

Command front-end that sits directly upstream of tiny_alu and drives its start/operand/op inputs. It buffers operation commands from a valid/ready source and issues them one at a time under tiny_alu's start/done protocol. Each result is returned on a valid/ready response port. It replaces the direct task-level driving of start_i in the bench and in the integrated design.

---
 rtl/tiny_alu_pkg.sv | 41 ++++
 rtl/tiny_alu_cmd_fifo.sv | 88 ++++++++
 rtl/tiny_alu_cmd_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_tiny_alu_cmd_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_alu_pkg.sv
// -----------------------------------------------------------------------------
// tiny_alu_pkg
// Shared types and constants for the tiny_alu command front-end.
//   operation_t  : 3-bit ALU operation encoding
//   seq_state_t  : sequencer FSM states
//   alu_cmd_t    : one buffered command {op, a, b}
//   bypasses_alu : true for ops answered without starting the ALU
// -----------------------------------------------------------------------------
package tiny_alu_pkg;

    localparam int OPERAND_W = 8;
    localparam int RESULT_W  = 16;
    localparam int OP_W      = 3;

    typedef enum logic [OP_W-1:0] {
        no_op  = 3'd0,
        add_op = 3'd1,
        and_op = 3'd2,
        xor_op = 3'd3,
        mul_op = 3'd4,
        rst_op = 3'd7
    } operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    typedef struct packed {
        operation_t           op;
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
    } alu_cmd_t;

    // no_op and rst_op never touch the ALU; they are answered with a zero result.
    function automatic logic bypasses_alu(input operation_t op);
        return (op == no_op) || (op == rst_op);
    endfunction

endpackage

// File: rtl/tiny_alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tiny_alu_cmd_fifo
// Synchronous command FIFO with asynchronous active-low reset.
// Ports:
//   clk_i, reset_n_i : clock (rising edge) and async active-low reset
//   push, push_data  : write request and entry; ignored while full
//   pop              : read request; ignored while empty
//   head             : entry at the read pointer (valid when !empty)
//   full, empty      : registered occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module tiny_alu_cmd_fifo
    import tiny_alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     reset_n_i,
    input  logic     push,
    input  alu_cmd_t push_data,
    input  logic     pop,
    output alu_cmd_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    alu_cmd_t         mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_eff_s;
    logic             pop_eff_s;

    assign push_eff_s = push && !full_r;
    assign pop_eff_s  = pop && !empty_r;
    assign head       = mem_r[rd_ptr_r];
    assign full       = full_r;
    assign empty      = empty_r;

    // Next occupancy; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({push_eff_s, pop_eff_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, count and flags; flags are registered from the next count.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_eff_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_eff_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_W'(DEPTH));
            empty_r <= (count_next_s == {CNT_W{1'b0}});
        end
    end

    // Storage array; cleared on reset so the head never shows stale X data.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_eff_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/tiny_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tiny_alu_cmd_sequencer
// Buffers ALU commands from a valid/ready source and issues them one at a
// time to tiny_alu using its start/done protocol; each result is returned in
// command order on a valid/ready response port.
// Ports:
//   clk_i, reset_n_i           : clock and async active-low reset
//   cmd_valid_i / cmd_ready_o  : command handshake (ready = buffer not full)
//   cmd_a_i, cmd_b_i, cmd_op_i : command payload
//   alu_start_o, alu_a_o, alu_b_o, alu_op_o : drive tiny_alu
//   alu_done_i, alu_result_i   : tiny_alu completion
//   rsp_valid_o / rsp_ready_i  : response handshake
//   rsp_result_o, rsp_op_o, rsp_error_o : response payload
// Optional feature: define TINY_ALU_CMD_SEQUENCER_TIMEOUT_EN to abort an ALU
// op after TIMEOUT_CYCLES busy cycles without done (rsp_error_o=1). Without
// it, BUSY waits indefinitely and rsp_error_o is tied low.
// -----------------------------------------------------------------------------
module tiny_alu_cmd_sequencer
    import tiny_alu_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [OPERAND_W-1:0] cmd_a_i,
    input  logic [OPERAND_W-1:0] cmd_b_i,
    input  logic [OP_W-1:0]      cmd_op_i,
    output logic                 alu_start_o,
    output logic [OPERAND_W-1:0] alu_a_o,
    output logic [OPERAND_W-1:0] alu_b_o,
    output logic [OP_W-1:0]      alu_op_o,
    input  logic                 alu_done_i,
    input  logic [RESULT_W-1:0]  alu_result_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [RESULT_W-1:0]  rsp_result_o,
    output logic [OP_W-1:0]      rsp_op_o,
    output logic                 rsp_error_o
);

    // Elaboration-time guard on parameter legality.
    if ((CMD_FIFO_DEPTH < 2) || ((CMD_FIFO_DEPTH & (CMD_FIFO_DEPTH - 1)) != 0) ||
        (TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 256)) begin : g_param_check
        $error("tiny_alu_cmd_sequencer: illegal CMD_FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    alu_cmd_t             push_data_s;
    alu_cmd_t             head_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 fifo_pop_s;
    logic                 cmd_push_s;

    seq_state_t           state_r;
    seq_state_t           state_next_s;

    logic                 alu_start_r;
    logic                 alu_start_next_s;
    logic [OPERAND_W-1:0] alu_a_r;
    logic [OPERAND_W-1:0] alu_a_next_s;
    logic [OPERAND_W-1:0] alu_b_r;
    logic [OPERAND_W-1:0] alu_b_next_s;
    operation_t           alu_op_r;
    operation_t           alu_op_next_s;

    logic                 rsp_valid_r;
    logic                 rsp_valid_next_s;
    logic [RESULT_W-1:0]  rsp_result_r;
    logic [RESULT_W-1:0]  rsp_result_next_s;
    operation_t           rsp_op_r;
    operation_t           rsp_op_next_s;

`ifdef TINY_ALU_CMD_SEQUENCER_TIMEOUT_EN
    // Last BUSY cycle index that may still complete normally.
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0]           to_cnt_r;
    logic [7:0]           to_cnt_next_s;
    logic                 rsp_error_r;
    logic                 rsp_error_next_s;
`endif

    assign cmd_ready_o  = !fifo_full_s;
    assign cmd_push_s   = cmd_valid_i && !fifo_full_s;
    assign push_data_s  = '{op: operation_t'(cmd_op_i), a: cmd_a_i, b: cmd_b_i};

    assign alu_start_o  = alu_start_r;
    assign alu_a_o      = alu_a_r;
    assign alu_b_o      = alu_b_r;
    assign alu_op_o     = alu_op_r;
    assign rsp_valid_o  = rsp_valid_r;
    assign rsp_result_o = rsp_result_r;
    assign rsp_op_o     = rsp_op_r;
`ifdef TINY_ALU_CMD_SEQUENCER_TIMEOUT_EN
    assign rsp_error_o  = rsp_error_r;
`else
    assign rsp_error_o  = 1'b0;
`endif

    tiny_alu_cmd_fifo #(
        .DEPTH     (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push      (cmd_push_s),
        .push_data (push_data_s),
        .pop       (fifo_pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // FSM next-state and next-output logic; every register holds by default.
    always_comb begin
        state_next_s      = state_r;
        fifo_pop_s        = 1'b0;
        alu_start_next_s  = alu_start_r;
        alu_a_next_s      = alu_a_r;
        alu_b_next_s      = alu_b_r;
        alu_op_next_s     = alu_op_r;
        rsp_valid_next_s  = rsp_valid_r;
        rsp_result_next_s = rsp_result_r;
        rsp_op_next_s     = rsp_op_r;
`ifdef TINY_ALU_CMD_SEQUENCER_TIMEOUT_EN
        rsp_error_next_s  = rsp_error_r;
        to_cnt_next_s     = to_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    if (bypasses_alu(head_s.op)) begin
                        rsp_valid_next_s  = 1'b1;
                        rsp_result_next_s = {RESULT_W{1'b0}};
                        rsp_op_next_s     = head_s.op;
`ifdef TINY_ALU_CMD_SEQUENCER_TIMEOUT_EN
                        rsp_error_next_s  = 1'b0;
`endif
                        state_next_s      = RESP;
                    end else begin
                        alu_start_next_s  = 1'b1;
                        alu_a_next_s      = head_s.a;
                        alu_b_next_s      = head_s.b;
                        alu_op_next_s     = head_s.op;
`ifdef TINY_ALU_CMD_SEQUENCER_TIMEOUT_EN
                        to_cnt_next_s     = 8'd0;
`endif
                        state_next_s      = BUSY;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                // Done has priority over a timeout landing in the same cycle.
                if (alu_done_i) begin
                    alu_start_next_s  = 1'b0;
                    rsp_valid_next_s  = 1'b1;
                    rsp_result_next_s = alu_result_i;
                    rsp_op_next_s     = alu_op_r;
`ifdef TINY_ALU_CMD_SEQUENCER_TIMEOUT_EN
                    rsp_error_next_s  = 1'b0;
                    to_cnt_next_s     = 8'd0;
`endif
                    state_next_s      = RESP;
                end
`ifdef TINY_ALU_CMD_SEQUENCER_TIMEOUT_EN
                else if (to_cnt_r == TIMEOUT_LIMIT) begin
                    alu_start_next_s  = 1'b0;
                    rsp_valid_next_s  = 1'b1;
                    rsp_result_next_s = {RESULT_W{1'b0}};
                    rsp_op_next_s     = alu_op_r;
                    rsp_error_next_s  = 1'b1;
                    to_cnt_next_s     = 8'd0;
                    state_next_s      = RESP;
                end else begin
                    to_cnt_next_s = to_cnt_r + 8'd1;
                end
`else
                else begin
                    alu_start_next_s = 1'b1;
                end
`endif
            end
            RESP: begin
                // Leaving through IDLE guarantees a start-low gap between ops.
                if (rsp_ready_i) begin
                    rsp_valid_next_s = 1'b0;
                    state_next_s     = IDLE;
                end else begin
                    rsp_valid_next_s = 1'b1;
                end
            end
            default: begin
                alu_start_next_s = 1'b0;
                rsp_valid_next_s = 1'b0;
                state_next_s     = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs; reset drops any in-flight op.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= IDLE;
            alu_start_r  <= 1'b0;
            alu_a_r      <= {OPERAND_W{1'b0}};
            alu_b_r      <= {OPERAND_W{1'b0}};
            alu_op_r     <= no_op;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= {RESULT_W{1'b0}};
            rsp_op_r     <= no_op;
        end else begin
            state_r      <= state_next_s;
            alu_start_r  <= alu_start_next_s;
            alu_a_r      <= alu_a_next_s;
            alu_b_r      <= alu_b_next_s;
            alu_op_r     <= alu_op_next_s;
            rsp_valid_r  <= rsp_valid_next_s;
            rsp_result_r <= rsp_result_next_s;
            rsp_op_r     <= rsp_op_next_s;
        end
    end

`ifdef TINY_ALU_CMD_SEQUENCER_TIMEOUT_EN
    // Timeout counter and error flag registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            to_cnt_r    <= 8'd0;
            rsp_error_r <= 1'b0;
        end else begin
            to_cnt_r    <= to_cnt_next_s;
            rsp_error_r <= rsp_error_next_s;
        end
    end
`endif

endmodule

// File: tb/tb_tiny_alu_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_tiny_alu_cmd_sequencer;

    logic        clk_i        = 1'b0;
    logic        reset_n_i    = 1'b0;
    logic        cmd_valid_i  = 1'b0;
    logic        cmd_ready_o;
    logic [7:0]  cmd_a_i      = 8'h00;
    logic [7:0]  cmd_b_i      = 8'h00;
    logic [2:0]  cmd_op_i     = 3'd0;
    logic        alu_start_o;
    logic [7:0]  alu_a_o;
    logic [7:0]  alu_b_o;
    logic [2:0]  alu_op_o;
    logic        alu_done_i   = 1'b0;
    logic [15:0] alu_result_i = 16'h0000;
    logic        rsp_valid_o;
    logic        rsp_ready_i  = 1'b0;
    logic [15:0] rsp_result_o;
    logic [2:0]  rsp_op_o;
    logic        rsp_error_o;

    typedef struct packed {
        logic [15:0] result;
        logic [2:0]  op;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_checks     = 0;
    int   n_fails      = 0;
    int   alu_lat      = 2;   // cycles of start before done; 0 = never done
    int   busy_cnt     = 0;
    int   start_rises  = 0;
    int   run_len      = 0;
    int   last_run_len = 0;
    int   starts_base  = 0;
    logic prev_start   = 1'b0;
    logic [7:0] cap_a  = 8'h00;
    logic [7:0] cap_b  = 8'h00;
    logic [2:0] cap_op = 3'd0;

    tiny_alu_cmd_sequencer dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_a_i      (cmd_a_i),
        .cmd_b_i      (cmd_b_i),
        .cmd_op_i     (cmd_op_i),
        .alu_start_o  (alu_start_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_op_o     (alu_op_o),
        .alu_done_i   (alu_done_i),
        .alu_result_i (alu_result_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o),
        .rsp_op_o     (rsp_op_o),
        .rsp_error_o  (rsp_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd1:    return {8'h00, a} + {8'h00, b};
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return {8'h00, a} * {8'h00, b};
            default: return 16'h0000;
        endcase
    endfunction

    // Monitor + ALU model, evaluated 1 ns after each falling edge.
    always begin
        rsp_t e;
        @(negedge clk_i);
        #1;
        if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_rsp: got result %h op %0d, required no response", rsp_result_o, rsp_op_o);
            end else begin
                e = exp_q.pop_front();
                check("rsp_result", 32'(rsp_result_o), 32'(e.result));
                check("rsp_op", 32'(rsp_op_o), 32'(e.op));
                check("rsp_error", 32'(rsp_error_o), 32'(e.err));
            end
        end
        if (alu_done_i) begin
            check("valid_after_done", 32'(rsp_valid_o), 32'd1);
        end
        if (alu_start_o) begin
            if (!prev_start) begin
                start_rises++;
                cap_a   = alu_a_o;
                cap_b   = alu_b_o;
                cap_op  = alu_op_o;
                run_len = 0;
            end else begin
                check("alu_a_stable", 32'(alu_a_o), 32'(cap_a));
                check("alu_b_stable", 32'(alu_b_o), 32'(cap_b));
                check("alu_op_stable", 32'(alu_op_o), 32'(cap_op));
            end
            run_len++;
            check("start_op_uses_alu", 32'((alu_op_o != 3'd0) && (alu_op_o != 3'd7)), 32'd1);
        end else if (prev_start) begin
            last_run_len = run_len;
        end
        prev_start = alu_start_o;
        if (alu_start_o) begin
            busy_cnt++;
            if ((alu_lat != 0) && (busy_cnt == alu_lat)) begin
                alu_done_i   = 1'b1;
                alu_result_i = alu_calc(alu_op_o, alu_a_o, alu_b_o);
            end else begin
                alu_done_i   = 1'b0;
                alu_result_i = 16'h0000;
            end
        end else begin
            busy_cnt     = 0;
            alu_done_i   = 1'b0;
            alu_result_i = 16'h0000;
        end
    end

    task automatic expect_rsp(input logic [15:0] r, input logic [2:0] op, input logic err);
        exp_q.push_back('{result: r, op: op, err: err});
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int w = 0;
        while (!cmd_ready_o && (w < 100)) begin
            @(negedge clk_i);
            w++;
        end
        if (!cmd_ready_o) begin
            n_checks++;
            n_fails++;
            $display("FAIL send_ready_timeout: cmd_ready_o=0, required 1");
        end
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_a_i     = a;
        cmd_b_i     = b;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        while ((exp_q.size() != 0) && (w < 300)) begin
            @(negedge clk_i);
            w++;
        end
        check({name, "_drained_pending"}, 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk_i);
        check("rst_alu_start", 32'(alu_start_o), 32'd0);
        check("rst_alu_a", 32'(alu_a_o), 32'd0);
        check("rst_alu_b", 32'(alu_b_o), 32'd0);
        check("rst_alu_op", 32'(alu_op_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_result", 32'(rsp_result_o), 32'd0);
        check("rst_rsp_op", 32'(rsp_op_o), 32'd0);
        check("rst_rsp_error", 32'(rsp_error_o), 32'd0);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);

        // Single add: start two cycles after the handshake
        rsp_ready_i = 1'b1;
        alu_lat     = 2;
        expect_rsp(16'h0046, 3'd1, 1'b0);
        send(3'd1, 8'h12, 8'h34);
        check("add_start_cycle1", 32'(alu_start_o), 32'd0);
        @(negedge clk_i);
        check("add_start_cycle2", 32'(alu_start_o), 32'd1);
        drain("add");

        // mul with a 3-cycle ALU
        alu_lat = 3;
        expect_rsp(16'hFE01, 3'd4, 1'b0);
        send(3'd4, 8'hFF, 8'hFF);
        drain("mul");
        check("mul_start_len", 32'(last_run_len), 32'd3);

        // Back-to-back commands under response backpressure
        rsp_ready_i = 1'b0;
        alu_lat     = 2;
        starts_base = start_rises;
        expect_rsp(16'h0030, 3'd2, 1'b0);
        expect_rsp(16'h00FF, 3'd3, 1'b0);
        expect_rsp(16'h0000, 3'd0, 1'b0);
        expect_rsp(16'h0100, 3'd1, 1'b0);
        expect_rsp(16'h0000, 3'd7, 1'b0);
        send(3'd2, 8'hF0, 8'h3C);
        send(3'd3, 8'hAA, 8'h55);
        send(3'd0, 8'h11, 8'h22);
        send(3'd1, 8'hFF, 8'h01);
        send(3'd7, 8'h33, 8'h44);
        check("b2b_cmd_ready_full", 32'(cmd_ready_o), 32'd0);
        repeat (3) @(negedge clk_i);
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid_o), 32'd1);
            check("bp_rsp_result", 32'(rsp_result_o), 32'h0030);
            check("bp_rsp_op", 32'(rsp_op_o), 32'd2);
            check("bp_alu_start", 32'(alu_start_o), 32'd0);
            check("bp_no_pop", 32'(cmd_ready_o), 32'd0);
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        drain("b2b");
        check("b2b_start_count", 32'(start_rises - starts_base), 32'd3);

        // Reset while BUSY with two commands buffered
        alu_lat = 0;
        send(3'd1, 8'h01, 8'h01);
        send(3'd1, 8'h02, 8'h02);
        send(3'd1, 8'h03, 8'h03);
        repeat (2) @(negedge clk_i);
        check("pre_reset_busy", 32'(alu_start_o), 32'd1);
        starts_base = start_rises;
        reset_n_i = 1'b0;
        #1;
        check("reset_start_low", 32'(alu_start_o), 32'd0);
        check("reset_valid_low", 32'(rsp_valid_o), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        alu_lat   = 2;
        @(negedge clk_i);
        check("post_reset_ready", 32'(cmd_ready_o), 32'd1);
        repeat (10) @(negedge clk_i);
        check("post_reset_no_start", 32'(start_rises - starts_base), 32'd0);
        expect_rsp(16'h00FF, 3'd3, 1'b0);
        send(3'd3, 8'h0F, 8'hF0);
        drain("post_reset");

`ifdef TINY_ALU_CMD_SEQUENCER_TIMEOUT_EN
        // ALU never answers: abort after 16 busy cycles, then recover
        alu_lat = 0;
        expect_rsp(16'h0000, 3'd1, 1'b1);
        send(3'd1, 8'h01, 8'h02);
        drain("timeout");
        check("timeout_start_len", 32'(last_run_len), 32'd16);
        alu_lat = 2;
        expect_rsp(16'h0005, 3'd1, 1'b0);
        send(3'd1, 8'h02, 8'h03);
        drain("after_timeout");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
